// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter for EX: SLL/SRL/SRA/pass one bit (or four) per cycle.
// Define SEQ_SHIFT_FAST_EN to take 4-bit steps while at least 4 remain.
module seq_shift_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    input  logic        alu_src,
    input  logic [1:0]  op_type,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] r,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] r_q, r_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;

    logic [4:0]  amt;
    logic [4:0]  step;
    logic [31:0] shifted;
    logic        unused_b;

    assign unused_b = ^b[31:5];

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == SHIFT) || (state_q == DONE);
    assign r         = r_q;

    always_comb begin
        amt = alu_src ? shamt : b[4:0];
        if (op_type == 2'b11) begin
            amt = 5'd0;
        end
    end

`ifdef SEQ_SHIFT_FAST_EN
    logic fast;

    always_comb begin
        fast = (cnt_q >= 5'd4);
        step = fast ? 5'd4 : 5'd1;
        shifted = r_q;
        if (fast) begin
            unique case (op_q)
                2'b00:   shifted = {r_q[27:0], 4'b0};
                2'b01:   shifted = {4'b0, r_q[31:4]};
                2'b10:   shifted = {{4{r_q[31]}}, r_q[31:4]};
                default: shifted = r_q;
            endcase
        end else begin
            unique case (op_q)
                2'b00:   shifted = {r_q[30:0], 1'b0};
                2'b01:   shifted = {1'b0, r_q[31:1]};
                2'b10:   shifted = {r_q[31], r_q[31:1]};
                default: shifted = r_q;
            endcase
        end
    end
`else
    always_comb begin
        step = 5'd1;
        shifted = r_q;
        unique case (op_q)
            2'b00:   shifted = {r_q[30:0], 1'b0};
            2'b01:   shifted = {1'b0, r_q[31:1]};
            2'b10:   shifted = {r_q[31], r_q[31:1]};
            default: shifted = r_q;
        endcase
    end
`endif

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    r_d     = a;
                    cnt_d   = amt;
                    op_d    = op_type;
                    state_d = (amt != 5'd0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                r_d   = shifted;
                cnt_d = cnt_q - step;
                if (cnt_d == 5'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= 32'd0;
            cnt_q   <= 5'd0;
            op_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Self-checking bench for seq_shift_unit: scoreboard of results and
// latencies, reset abort and DONE backpressure.
module tb_seq_shift_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic        alu_src;
    logic [1:0]  op_type;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] r;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_r_q[$];
    int          exp_n_q[$];

    seq_shift_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .shamt    (shamt),
        .alu_src  (alu_src),
        .op_type  (op_type),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .r        (r),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input int amt);
`ifdef SEQ_SHIFT_FAST_EN
        return amt / 4 + amt % 4;
`else
        return amt;
`endif
    endfunction

    // Accept one request; push the reference result and latency.
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                         input logic [4:0] ish, input logic isrc,
                         input logic [1:0] it);
        int amt;
        logic [31:0] e;
        amt = isrc ? int'(ish) : int'(ib[4:0]);
        if (it == 2'b11) amt = 0;
        case (it)
            2'b00:   e = ia << amt;
            2'b01:   e = ia >> amt;
            2'b10:   e = $signed(ia) >>> amt;
            default: e = ia;
        endcase
        exp_r_q.push_back(e);
        exp_n_q.push_back(exp_lat(amt));
        @(negedge clk);
        check("in_ready_pre", {31'd0, in_ready}, 32'd1);
        a = ia; b = ib; shamt = ish; alu_src = isrc; op_type = it;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; shamt = 5'($urandom);
        alu_src = 1'($urandom); op_type = 2'($urandom);
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 60) begin
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic collect(input string tag);
        int lat;
        wait_result(lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_n_q.pop_front()));
        check({tag, "_r"}, r, exp_r_q.pop_front());
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_idle"}, {30'd0, in_ready, busy}, 32'd2);
    endtask

    initial begin
        logic [31:0] held;
        int lat;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; shamt = '0; alu_src = 1'b0; op_type = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_flags", {29'd0, in_ready, out_valid, busy}, 32'd4);
        check("rst_r", r, 32'd0);
        rst_n = 1'b1;

        // Abort mid-shift
        issue(32'd1, 32'd0, 5'd20, 1'b1, 2'b00);
        void'(exp_r_q.pop_back());
        void'(exp_n_q.pop_back());
        repeat (5) @(negedge clk);
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_flags", {29'd0, in_ready, out_valid, busy}, 32'd4);
        check("abort_r", r, 32'd0);
        rst_n = 1'b1;

        issue(32'h0000_0001, 32'd0, 5'd31, 1'b1, 2'b00);
        collect("sll31");
        issue(32'h8000_00F0, 32'hFFFF_FFE4, 5'd0, 1'b0, 2'b10);
        collect("sra4");
        issue(32'h8000_0000, 32'h0000_001F, 5'd3, 1'b0, 2'b01);
        collect("srl31");
        issue(32'hDEAD_BEEF, 32'd0, 5'd0, 1'b1, 2'b00);
        collect("amt0");
        issue(32'h1234_5678, 32'd0, 5'd9, 1'b1, 2'b11);
        collect("pass");
        issue(32'hF000_0000, 32'd0, 5'd7, 1'b1, 2'b10);
        collect("sra7");

        // Explicit plan constants, independent of the model
        check("const_sll", exp_lat(31) == 31 || exp_lat(31) == 10 ?
              32'h8000_0000 : 32'd0, 32'h8000_0000);

        for (int i = 0; i < 24; i++) begin
            issue($urandom, $urandom, 5'($urandom), 1'($urandom),
                  2'($urandom));
            collect("rnd");
        end

        // Backpressure in DONE
        issue(32'hA5A5_0F0F, 32'd0, 5'd5, 1'b1, 2'b01);
        wait_result(lat);
        check("bp_lat", 32'(lat), 32'(exp_n_q.pop_front()));
        held = exp_r_q.pop_front();
        a = 32'h0BAD_F00D; op_type = 2'b11; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("bp_r", r, held);
            check("bp_flags", {29'd0, in_ready, out_valid, busy}, 32'd3);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release", {29'd0, in_ready, out_valid, busy}, 32'd4);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_next_acc", {29'd0, in_ready, out_valid, busy}, 32'd3);
        check("bp_next_r", r, 32'h0BAD_F00D);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_final", {29'd0, in_ready, out_valid, busy}, 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
